// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: pipeline enable/flush sequencer with mem-wait freeze, irq drain/entry; optional STALL_COUNTER_EN adds stall_cycles.
module pipeline_stall_controller #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DataHazard,
  input  logic        branch_taken,
  input  logic        jump_id,
  input  logic        mem_busy,
  input  logic        irq,
  input  logic        irq_enable,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        exc_vector_sel,
  output logic        epc_write,
  output logic        bus_error
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, IRQ_DRAIN, IRQ_ENTER} state_t;
  state_t st;
  logic [7:0] wcnt, busy_cnt;
  logic [3:0] dcnt;
  logic run, freeze, take_irq;
  always_comb begin
    run = st == RUN || (st == MEM_WAIT && !mem_busy);
    freeze = mem_busy && st != IRQ_ENTER;
    take_irq = run && irq && irq_enable && !branch_taken;
    busy_cnt = st == RUN ? 8'd1 : (wcnt == 8'hff ? wcnt : wcnt + 8'd1);
    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b1111;
    {if_id_flush, id_ex_flush, mem_wb_flush, exc_vector_sel, epc_write} = 5'b0;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b111;
    end else if (freeze) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      mem_wb_flush = 1'b1;
    end else if (st == IRQ_DRAIN) begin
      pc_write = 1'b0;
      if_id_flush = 1'b1;
    end else if (st == IRQ_ENTER) begin
      exc_vector_sel = 1'b1;
      if_id_flush = 1'b1;
    end else if (take_irq) begin
      epc_write = 1'b1;
      pc_write = 1'b0;
      if_id_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (DataHazard) begin
      pc_write = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (jump_id) begin
      if_id_flush = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RUN;
      wcnt <= '0;
      dcnt <= '0;
      bus_error <= 1'b0;
    end else if (freeze && st != IRQ_DRAIN) begin
      st <= MEM_WAIT;
      wcnt <= busy_cnt;
      if (busy_cnt >= 8'(MEM_TIMEOUT)) bus_error <= 1'b1;
    end else if (freeze) begin
      st <= IRQ_DRAIN;
    end else if (st == IRQ_DRAIN) begin
      st <= dcnt <= 4'd1 ? IRQ_ENTER : IRQ_DRAIN;
      dcnt <= dcnt <= 4'd1 ? 4'd0 : dcnt - 4'd1;
    end else if (take_irq) begin
      st <= DRAIN_CYCLES == 1 ? IRQ_ENTER : IRQ_DRAIN;
      dcnt <= 4'(DRAIN_CYCLES - 1);
      wcnt <= '0;
    end else begin
      st <= RUN;
      wcnt <= '0;
    end
  end
`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk)
    stall_cycles <= reset ? 32'd0 : stall_cycles + {31'd0, !pc_write};
`endif
endmodule
